imem_stream_loader: RTL and testbench

- Writer-side counterpart to the instruction ROM: receives a framed byte stream (from the UART/debug bridge) and writes 16-bit instruction words into the 1024-entry instruction RAM at 10-bit word addresses.
- Holds the core in reset while loading, verifies a checksum, and flags done or error.
- Sits between the byte-stream source and the instruction RAM write port; the fetch path is unchanged.

---
 rtl/imem_stream_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_stream_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_stream_loader.sv
// Framed byte-stream loader for the instruction RAM.
// Holds the core while loading; checks an XOR checksum.
module imem_stream_loader #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_WORDS      = 1024
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic        Start,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        ByteReady,
  output logic        ImemWriteEn,
  output logic [9:0]  ImemAddress,
  output logic [15:0] ImemWriteData,
  output logic        CoreHold,
  output logic        LoadBusy,
  output logic        LoadDone,
  output logic        LoadError
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI,
    S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     cnt_hi_q, cnt_hi_d;
  logic [10:0]    cnt_q, cnt_d;
  logic [10:0]    words_q, words_d;
  logic [9:0]     addr_q, addr_d;
  logic [7:0]     xor_q, xor_d;
  logic [7:0]     hi_q, hi_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           we_q, we_d;
  logic [9:0]     waddr_q, waddr_d;
  logic [15:0]    wdata_q, wdata_d;

  logic        rx;
  logic        acc;
  logic [15:0] n16;

  assign rx  = state_q inside {S_CNT_HI, S_CNT_LO, S_DATA_HI,
                               S_DATA_LO, S_CHECK};
  assign acc = rx && ByteValid;
  assign n16 = {cnt_hi_q, ByteData};

  assign ByteReady     = rx;
  assign ImemWriteEn   = we_q;
  assign ImemAddress   = waddr_q;
  assign ImemWriteData = wdata_q;
  assign LoadBusy      = rx;
  assign LoadDone      = state_q == S_DONE;
  assign LoadError     = state_q == S_ERROR;
  // A failed image keeps the core held until a good load replaces it.
  assign CoreHold      = rx || state_q == S_ERROR;

  always_comb begin
    state_d  = state_q;
    cnt_hi_d = cnt_hi_q;
    cnt_d    = cnt_q;
    words_d  = words_q;
    addr_d   = addr_q;
    xor_d    = xor_q;
    hi_d     = hi_q;
    tmo_d    = tmo_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          state_d = S_CNT_HI;
          addr_d  = '0;
          words_d = '0;
          xor_d   = '0;
          tmo_d   = '0;
        end
      end
      S_CNT_HI: begin
        if (acc) begin
          cnt_hi_d = ByteData;
          state_d  = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (acc) begin
          if (n16 == '0 || n16 > MAX_N) begin
            state_d = S_ERROR;
          end else begin
            cnt_d   = n16[10:0];
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (acc) begin
          hi_d    = ByteData;
          xor_d   = xor_q ^ ByteData;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (acc) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {hi_q, ByteData};
          addr_d  = addr_q + 10'd1;
          words_d = words_q + 11'd1;
          xor_d   = xor_q ^ ByteData;
          state_d = (words_q + 11'd1 == cnt_q) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (acc) begin
          state_d = (ByteData == xor_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (acc) begin
      tmo_d = '0;
    end else if (rx) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_ERROR;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q  <= S_IDLE;
      cnt_hi_q <= '0;
      cnt_q    <= '0;
      words_q  <= '0;
      addr_q   <= '0;
      xor_q    <= '0;
      hi_q     <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_hi_q <= cnt_hi_d;
      cnt_q    <= cnt_d;
      words_q  <= words_d;
      addr_q   <= addr_d;
      xor_q    <= xor_d;
      hi_q     <= hi_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized self-checking bench for imem_stream_loader.
// Expected writes/outcomes come from the frame rules directly.
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        Start;
  logic        ByteValid;
  logic [7:0]  ByteData;
  logic        ByteReady;
  logic        ImemWriteEn;
  logic [9:0]  ImemAddress;
  logic [15:0] ImemWriteData;
  logic        CoreHold;
  logic        LoadBusy;
  logic        LoadDone;
  logic        LoadError;

  int vecs = 0;
  int errs = 0;

  logic [9:0]  wa_q[$];
  logic [15:0] wd_q[$];

  imem_stream_loader #(.TIMEOUT_CYCLES(16), .MAX_WORDS(1024)) dut (
    .clk(clk), .sync_rst(sync_rst), .Start(Start),
    .ByteValid(ByteValid), .ByteData(ByteData),
    .ByteReady(ByteReady), .ImemWriteEn(ImemWriteEn),
    .ImemAddress(ImemAddress), .ImemWriteData(ImemWriteData),
    .CoreHold(CoreHold), .LoadBusy(LoadBusy),
    .LoadDone(LoadDone), .LoadError(LoadError)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ImemWriteEn === 1'b1) begin
      wa_q.push_back(ImemAddress);
      wd_q.push_back(ImemWriteData);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles; returns just after its accept edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) step();
    ByteValid = 1'b1;
    ByteData  = b;
    n = 0;
    while (ByteReady !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) begin
      vecs++;
      errs++;
      $display("FAIL send_wait byte=%02h ByteReady=%b need 1", b, ByteReady);
    end
    step();
    ByteValid = 1'b0;
  endtask

  function automatic logic [7:0] xsum(input logic [15:0] w[$]);
    logic [7:0] x = 8'h00;
    foreach (w[i]) x ^= w[i][15:8] ^ w[i][7:0];
    return x;
  endfunction

  task automatic send_frame(input logic [15:0] w[$], input logic [7:0] ck,
                            input int maxgap);
    logic [15:0] n = 16'(w.size());
    send(n[15:8], $urandom_range(maxgap));
    send(n[7:0], $urandom_range(maxgap));
    foreach (w[i]) begin
      send(w[i][15:8], $urandom_range(maxgap));
      send(w[i][7:0], $urandom_range(maxgap));
    end
    send(ck, $urandom_range(maxgap));
  endtask

  task automatic test_reset();
    sync_rst = 1'b1;
    repeat (3) step();
    sync_rst = 1'b0;
    vecs++;
    if ({ByteReady, ImemWriteEn, CoreHold, LoadBusy, LoadDone, LoadError} !== 6'b0) begin
      errs++;
      $display("FAIL reset_flags got %b need 000000",
               {ByteReady, ImemWriteEn, CoreHold, LoadBusy, LoadDone, LoadError});
    end
    vecs++;
    if ({ImemAddress, ImemWriteData} !== 26'b0) begin
      errs++;
      $display("FAIL reset_bus got %h/%h need 0/0", ImemAddress, ImemWriteData);
    end
  endtask

  task automatic test_basic();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    vecs++;
    if ({CoreHold, LoadBusy, LoadDone, LoadError} !== 4'b1100) begin
      errs++;
      $display("FAIL start_flags got %b need 1100",
               {CoreHold, LoadBusy, LoadDone, LoadError});
    end
    send(8'h00, 0); send(8'h02, 1); send(8'hD1, 0); send(8'h8E, 2);
    vecs++;
    if (ImemWriteEn !== 1'b1 || ImemAddress !== 10'h000 || ImemWriteData !== 16'hD18E) begin
      errs++;
      $display("FAIL basic_w0 got en=%b %h=%h need 1 000=d18e",
               ImemWriteEn, ImemAddress, ImemWriteData);
    end
    send(8'hD5, 0);
    vecs++;
    if (ImemWriteEn !== 1'b0) begin
      errs++;
      $display("FAIL basic_strobe_len got %b need 0", ImemWriteEn);
    end
    send(8'h90, 1);
    vecs++;
    if (ImemWriteEn !== 1'b1 || ImemAddress !== 10'h001 || ImemWriteData !== 16'hD590) begin
      errs++;
      $display("FAIL basic_w1 got en=%b %h=%h need 1 001=d590",
               ImemWriteEn, ImemAddress, ImemWriteData);
    end
    send(8'h1A, 0);
    repeat (3) step();
    vecs++;
    if ({CoreHold, LoadBusy, LoadDone, LoadError} !== 4'b0010) begin
      errs++;
      $display("FAIL basic_done got %b need 0010",
               {CoreHold, LoadBusy, LoadDone, LoadError});
    end
    vecs++;
    if (wa_q.size() !== 2) begin
      errs++;
      $display("FAIL basic_nwrites got %0d need 2", wa_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    logic [15:0] w[$] = '{16'hD18E, 16'hD590};
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_frame(w, xsum(w) ^ 8'h01, 2);
    repeat (2) step();
    vecs++;
    if (wa_q.size() !== 2 || wd_q[1] !== 16'hD590) begin
      errs++;
      $display("FAIL badck_writes got n=%0d need 2", wa_q.size());
    end
    vecs++;
    if ({CoreHold, LoadBusy, LoadDone, LoadError} !== 4'b1001) begin
      errs++;
      $display("FAIL badck_flags got %b need 1001",
               {CoreHold, LoadBusy, LoadDone, LoadError});
    end
    pulse_start();
    send_frame(w, xsum(w), 2);
    step();
    vecs++;
    if ({CoreHold, LoadBusy, LoadDone, LoadError} !== 4'b0010) begin
      errs++;
      $display("FAIL badck_retry got %b need 0010",
               {CoreHold, LoadBusy, LoadDone, LoadError});
    end
  endtask

  task automatic test_bad_count();
    logic [15:0] cnts[2] = '{16'h0000, 16'h0401};
    foreach (cnts[k]) begin
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send(cnts[k][15:8], 1);
      send(cnts[k][7:0], 0);
      vecs++;
      if ({ByteReady, CoreHold, LoadBusy, LoadError} !== 4'b0101) begin
        errs++;
        $display("FAIL badcnt_%04h got %b need 0101", cnts[k],
                 {ByteReady, CoreHold, LoadBusy, LoadError});
      end
      repeat (4) step();
      vecs++;
      if (wa_q.size() !== 0) begin
        errs++;
        $display("FAIL badcnt_writes_%04h got %0d need 0", cnts[k], wa_q.size());
      end
    end
  endtask

  task automatic test_timeout();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send(8'h00, 0); send(8'h01, 0); send(8'hD1, 0);
    repeat (15) step();
    vecs++;
    if (LoadError !== 1'b0 || LoadBusy !== 1'b1) begin
      errs++;
      $display("FAIL tmo_early got err=%b busy=%b need 0 1", LoadError, LoadBusy);
    end
    step();
    vecs++;
    if (LoadError !== 1'b1 || CoreHold !== 1'b1) begin
      errs++;
      $display("FAIL tmo_fire got err=%b hold=%b need 1 1", LoadError, CoreHold);
    end
    repeat (3) step();
    vecs++;
    if (wa_q.size() !== 0) begin
      errs++;
      $display("FAIL tmo_writes got %0d need 0", wa_q.size());
    end
  endtask

  task automatic test_full();
    logic [15:0] w[$];
    int bad = 0;
    for (int i = 0; i < 1024; i++) w.push_back(16'($urandom));
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_frame(w, xsum(w), 3);
    repeat (3) step();
    vecs++;
    if (wa_q.size() !== 1024) begin
      errs++;
      $display("FAIL full_nwrites got %0d need 1024", wa_q.size());
    end
    for (int i = 0; i < wa_q.size() && i < 1024; i++)
      if (wa_q[i] !== 10'(i) || wd_q[i] !== w[i]) bad++;
    vecs++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL full_data got %0d bad words need 0", bad);
    end
    vecs++;
    if ({CoreHold, LoadDone, LoadError} !== 3'b010) begin
      errs++;
      $display("FAIL full_done got %b need 010", {CoreHold, LoadDone, LoadError});
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w[5];
    foreach (w[i]) w[i] = 16'($urandom);
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send(8'h00, 0); send(8'h05, 0);
    for (int i = 0; i < 3; i++) begin
      send(w[i][15:8], 1);
      send(w[i][7:0], 0);
      if (i == 1) pulse_start();
    end
    vecs++;
    if (LoadBusy !== 1'b1) begin
      errs++;
      $display("FAIL mid_start_busy got %b need 1", LoadBusy);
    end
    send(w[3][15:8], 0);
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    vecs++;
    if ({ByteReady, ImemWriteEn, CoreHold, LoadBusy, LoadDone, LoadError} !== 6'b0) begin
      errs++;
      $display("FAIL mid_rst_flags got %b need 000000",
               {ByteReady, ImemWriteEn, CoreHold, LoadBusy, LoadDone, LoadError});
    end
    ByteValid = 1'b1;
    ByteData  = w[3][7:0];
    repeat (3) step();
    ByteValid = 1'b0;
    step();
    vecs++;
    if (wa_q.size() !== 3) begin
      errs++;
      $display("FAIL mid_nwrites got %0d need 3", wa_q.size());
    end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      vecs++;
      if (wa_q[i] !== 10'(i) || wd_q[i] !== w[i]) begin
        errs++;
        $display("FAIL mid_w%0d got %h=%h need %h=%h",
                 i, wa_q[i], wd_q[i], 10'(i), w[i]);
      end
    end
  endtask

  initial begin
    sync_rst  = 1'b1;
    Start     = 1'b0;
    ByteValid = 1'b0;
    ByteData  = 8'h00;
    step();
    test_reset();
    test_basic();
    test_bad_checksum();
    test_bad_count();
    test_timeout();
    test_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
